// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit, 2-bit-field CPU: widths, opcodes,
// instruction field positions and the fetch state encoding.
package cpu_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  // Field layout: op[7:6] rs[5:4] rt[3:2] rd[1:0], jump target in [5:0]
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int RS_MSB = 5;
  localparam int RS_LSB = 4;
  localparam int RT_MSB = 3;
  localparam int RT_LSB = 2;
  localparam int RD_MSB = 1;
  localparam int RD_LSB = 0;
  localparam int JTGT_W = 6;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC priority mux: redirect, hold, page-relative jump,
// then sequential increment. Also flags a jump-to-self seen while running.
module fetch_next_pc
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               stall,
  input  logic               halt_state,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               halt_hit
);

  logic              jump_hit;
  logic [ADDR_W-1:0] jump_tgt;

  assign jump_hit = (instr[OP_MSB:OP_LSB] == OP_J);
  // Target stays inside the current 64-byte page
  assign jump_tgt = {pc[ADDR_W-1:JTGT_W], instr[JTGT_W-1:0]};

  // Priority: redirect > hold (stall or halted) > jump > increment
  always_comb begin
    next_pc  = pc + 1'b1;
    halt_hit = 1'b0;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (stall || halt_state) begin
      next_pc = pc;
    end else if (jump_hit) begin
      next_pc  = jump_tgt;
      halt_hit = (jump_tgt == pc);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC and IF/ID register for the 8-bit CPU. Jumps resolve here with no
// bubble; a jump to its own address parks fetch in HALT until redirected.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FS_RUN  | fetching; IR captures instr_in every unstalled cycle
// FS_HALT | jump-to-self seen; PC frozen, IR invalid, exit via redirect
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  output logic               halted
);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              halt_hit;

  fetch_next_pc #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_next_pc (
    .pc             (pc_out),
    .instr          (instr_in),
    .stall          (stall),
    .halt_state     (state == FS_HALT),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .next_pc        (pc_nxt),
    .halt_hit       (halt_hit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= FS_RUN;
    else          state <= state_nxt;
  end

  // Next state: redirect always resumes; a running jump-to-self halts
  always_comb begin
    state_nxt = state;
    if (redirect_valid)  state_nxt = FS_RUN;
    else if (halt_hit)   state_nxt = FS_HALT;
  end

  assign halted = (state == FS_HALT);

  // Program counter
  always_ff @(posedge clk) begin
    if (!reset_n) pc_out <= RESET_PC;
    else          pc_out <= pc_nxt;
  end

  // IF/ID register; redirect flushes even while stalled, data fields hold
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_out   <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (redirect_valid) begin
      ir_valid <= 1'b0;
    end else if (stall) begin
      ir_valid <= ir_valid;
    end else if (state == FS_RUN) begin
      ir_out   <= instr_in;
      ir_pc    <= pc_out;
      ir_valid <= 1'b1;
    end else begin
      ir_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small combinational program memory.
module tb_fetch_unit;

  logic       clk;
  logic       reset_n;
  logic [7:0] pc_out;
  logic [7:0] instr_in;
  logic       stall;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic [7:0] ir_out;
  logic [7:0] ir_pc;
  logic       ir_valid;
  logic       halted;

  logic [7:0] mem [256];

  int checks;
  int failures;

  fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_out         (pc_out),
    .instr_in       (instr_in),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir_out         (ir_out),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .halted         (halted)
  );

  assign instr_in = mem[pc_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_pc  [6] = '{8'h01, 8'h02, 8'h03, 8'h02, 8'h03, 8'h02};
  logic [7:0] exp_ir  [6] = '{8'h44, 8'h49, 8'h2A, 8'hC2, 8'h2A, 8'hC2};
  logic [7:0] exp_irp [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h02, 8'h03};

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0]    = 8'h44;
    mem[1]    = 8'h49;
    mem[2]    = 8'h2A;
    mem[3]    = 8'hC2;
    mem[5]    = 8'hC5;
    mem[8'hFF] = 8'h00;

    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    tick();
    tick();
    chk("rst_pc", pc_out, 8'h00);
    chk("rst_ir", ir_out, 8'h00);
    chk("rst_irpc", ir_pc, 8'h00);
    chk("rst_valid", ir_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);

    // Program loop with jump back to 2: no bubble after the jump
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("loop_pc", pc_out, exp_pc[i]);
      chk("loop_ir", ir_out, exp_ir[i]);
      chk("loop_irpc", ir_pc, exp_irp[i]);
      chk("loop_valid", ir_valid, 1'b1);
    end

    // Stall two cycles while pc_out=2
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("pre_stall_pc", pc_out, 8'h02);
    chk("pre_stall_ir", ir_out, 8'h49);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_pc", pc_out, 8'h02);
      chk("stall_ir", ir_out, 8'h49);
      chk("stall_valid", ir_valid, 1'b1);
    end
    stall = 1'b0;
    tick();
    chk("resume_pc", pc_out, 8'h03);
    chk("resume_ir", ir_out, 8'h2A);
    tick();
    chk("resume_pc2", pc_out, 8'h02);
    chk("resume_ir2", ir_out, 8'hC2);

    // Reset mid-run at pc_out=3
    tick();
    chk("mid_pc3", pc_out, 8'h03);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_pc", pc_out, 8'h00);
    chk("mid_rst_valid", ir_valid, 1'b0);
    chk("mid_rst_halted", halted, 1'b0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_pc", pc_out, 8'h01);
    chk("post_rst_ir", ir_out, 8'h44);
    chk("post_rst_valid", ir_valid, 1'b1);

    // Redirect to jump-to-self at 5 -> HALT
    redirect_valid = 1'b1;
    redirect_pc    = 8'h05;
    tick();
    chk("redir5_pc", pc_out, 8'h05);
    chk("redir5_valid", ir_valid, 1'b0);
    chk("redir5_ir_hold", ir_out, 8'h44);
    redirect_valid = 1'b0;
    tick();
    chk("halt_ir", ir_out, 8'hC5);
    chk("halt_irpc", ir_pc, 8'h05);
    chk("halt_valid1", ir_valid, 1'b1);
    chk("halt_flag", halted, 1'b1);
    chk("halt_pc", pc_out, 8'h05);
    tick();
    chk("halt_valid0", ir_valid, 1'b0);
    chk("halt_flag2", halted, 1'b1);
    chk("halt_pc2", pc_out, 8'h05);
    stall = 1'b1;
    tick();
    chk("halt_stall_flag", halted, 1'b1);
    chk("halt_stall_pc", pc_out, 8'h05);
    stall = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h00;
    tick();
    chk("unhalt_flag", halted, 1'b0);
    chk("unhalt_pc", pc_out, 8'h00);
    chk("unhalt_valid", ir_valid, 1'b0);
    redirect_valid = 1'b0;
    tick();
    chk("unhalt_ir", ir_out, 8'h44);
    chk("unhalt_valid2", ir_valid, 1'b1);
    chk("unhalt_pc2", pc_out, 8'h01);

    // Redirect to FF and wrap to 00
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFF;
    tick();
    chk("wrap_pc_ff", pc_out, 8'hFF);
    chk("wrap_flush", ir_valid, 1'b0);
    redirect_valid = 1'b0;
    tick();
    chk("wrap_pc_00", pc_out, 8'h00);
    chk("wrap_ir", ir_out, 8'h00);
    chk("wrap_irpc", ir_pc, 8'hFF);
    chk("wrap_valid", ir_valid, 1'b1);
    tick();
    chk("wrap_next_ir", ir_out, 8'h44);
    tick();
    chk("sr_pre_pc", pc_out, 8'h02);

    // Stall and redirect together: redirect wins, IR flushed
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h01;
    tick();
    chk("sr_pc", pc_out, 8'h01);
    chk("sr_valid", ir_valid, 1'b0);
    chk("sr_ir_hold", ir_out, 8'h49);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    tick();
    chk("sr_resume_ir", ir_out, 8'h49);
    chk("sr_resume_irpc", ir_pc, 8'h01);
    chk("sr_resume_valid", ir_valid, 1'b1);
    tick();
    chk("rj_pre_pc", pc_out, 8'h03);

    // Redirect while a jump is on instr_in: jump dropped
    redirect_valid = 1'b1;
    redirect_pc    = 8'h00;
    tick();
    chk("rj_pc", pc_out, 8'h00);
    chk("rj_valid", ir_valid, 1'b0);
    redirect_valid = 1'b0;
    tick();
    chk("rj_next_ir", ir_out, 8'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
